// File: rtl/alu_result_stage_pkg.sv
// Shared ALU package.
// Provides the data/opcode widths, the result FIFO state encoding and the
// queued entry layout (result, flags, opcode tag).
package alu_result_stage_pkg;

  localparam int DATA_W = 16;
  localparam int OP_W   = 4;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } fifo_state_e;

  typedef struct packed {
    logic [DATA_W-1:0] s;
    logic              zero;
    logic              neg;
    logic              ovf;
    logic [OP_W-1:0]   op;
  } entry_t;

endpackage

// File: rtl/alu_flag_gen.sv
// Combinational status flag generator for an ALU result.
// Ports:
//   s    - ALU/shifter result
//   cout - carry or sign-change flag from the ALU op
//   zero - result is all zeros
//   neg  - result MSB
//   ovf  - cout passed through
module alu_flag_gen
  import alu_result_stage_pkg::*;
(
  input  logic [DATA_W-1:0] s,
  input  logic              cout,
  output logic              zero,
  output logic              neg,
  output logic              ovf
);

  assign zero = (s == '0);
  assign neg  = s[DATA_W-1];
  assign ovf  = cout;

endmodule

// File: rtl/alu_result_stage.sv
// ALU result stage: a 2-entry valid/ready FIFO that registers the ALU result,
// attaches zero/neg/ovf flags at push time, and keeps sticky overflow status.
// Ports:
//   clk, rst_n                 - clock, synchronous active-low reset
//   in_valid/in_ready          - upstream handshake
//   in_s, in_cout, in_op       - ALU result, carry flag, opcode tag
//   out_valid/out_ready        - downstream handshake
//   out_s, out_zero, out_neg,
//   out_ovf, out_op            - oldest queued entry (all 0 when empty)
//   clr_sticky                 - clears sticky_ovf and ovf_count
//   sticky_ovf                 - an accepted result had in_cout=1 since clear
//   ovf_count                  - saturating count of such results
module alu_result_stage
  import alu_result_stage_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_s,
  input  logic              in_cout,
  input  logic [OP_W-1:0]   in_op,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_s,
  output logic              out_zero,
  output logic              out_neg,
  output logic              out_ovf,
  output logic [OP_W-1:0]   out_op,
  input  logic              clr_sticky,
  output logic              sticky_ovf,
  output logic [7:0]        ovf_count
);

  fifo_state_e state_q, state_d;
  entry_t      head_q, tail_q, new_e;
  logic        push, pop, cnt_push;

  alu_flag_gen u_flags (
    .s    (in_s),
    .cout (in_cout),
    .zero (new_e.zero),
    .neg  (new_e.neg),
    .ovf  (new_e.ovf)
  );
  assign new_e.s  = in_s;
  assign new_e.op = in_op;

  // Handshakes depend on registered state only (and reset), never on out_ready.
  assign in_ready  = rst_n & (state_q != FULL);
  assign out_valid = rst_n & (state_q != EMPTY);
  assign push      = in_valid & in_ready;
  assign pop       = out_valid & out_ready;
  assign cnt_push  = push & in_cout;

  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= EMPTY;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      EMPTY:   if (push)         state_d = ONE;
      ONE: begin
        if (push && !pop)        state_d = FULL;
        else if (!push && pop)   state_d = EMPTY;
      end
      FULL:    if (pop)          state_d = ONE;
      default:                   state_d = EMPTY;
    endcase
  end

  // head_q is always the oldest entry; tail_q only holds data in FULL.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      head_q <= '0;
      tail_q <= '0;
    end else begin
      case (state_q)
        EMPTY: if (push) head_q <= new_e;
        ONE: begin
          if (push && pop) head_q <= new_e;
          else if (push)   tail_q <= new_e;
        end
        FULL:  if (pop)  head_q <= tail_q;
        default: ;
      endcase
    end
  end

  // head_q may be stale after the last pop, so outputs are masked when empty.
  assign out_s    = out_valid ? head_q.s    : '0;
  assign out_zero = out_valid & head_q.zero;
  assign out_neg  = out_valid & head_q.neg;
  assign out_ovf  = out_valid & head_q.ovf;
  assign out_op   = out_valid ? head_q.op   : '0;

  // A counting push in the same cycle as a clear wins over the clear.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sticky_ovf <= 1'b0;
      ovf_count  <= 8'h00;
    end else begin
      if (cnt_push)        sticky_ovf <= 1'b1;
      else if (clr_sticky) sticky_ovf <= 1'b0;

      if (clr_sticky)                          ovf_count <= cnt_push ? 8'h01 : 8'h00;
      else if (cnt_push && ovf_count != 8'hFF) ovf_count <= ovf_count + 8'h01;
    end
  end

endmodule
